// File: rtl/hazard_pkg.sv
// Shared constants for the register-countdown hazard scoreboard.
package hazard_pkg;

  // Producer latencies: cycles until a result can be forwarded.
  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_LOAD = 2;
  localparam int unsigned LAT_MULT = 4;

  // A source consumed in ID tolerates no pending count; one consumed in EX tolerates one.
  localparam int unsigned SLACK_ID = 0;
  localparam int unsigned SLACK_EX = 1;

endpackage

// File: rtl/sb_counter.sv
// Countdown for one architectural register. A load never shortens a pending count.
module sb_counter #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] dec;

  always_comb begin
    dec = '0;
    if (cnt_q != '0) dec = cnt_q - LAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (load && (lat > dec)) cnt_q <= lat;
    else                         cnt_q <= dec;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard driving PC / IF-ID
// advance and ID/EX control flush, with stall accounting and a stuck-stall flag.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_LAT  = 4,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Valid_ID,
  input  logic [REG_AW-1:0] Rs_ID,
  input  logic [REG_AW-1:0] Rt_ID,
  input  logic              UseRs_ID,
  input  logic              UseRt_ID,
  input  logic              Early_ID,
  input  logic              RegWrite_ID,
  input  logic [REG_AW-1:0] Dest_ID,
  input  logic [LAT_W-1:0]  Lat_ID,
  input  logic              Flush_EX,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              FlushControl,
  output logic [CNT_W-1:0]  StallCycles,
  output logic              HazardError
);

  localparam int unsigned      RUN_W     = LAT_W + 1;
  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_LAT + 1);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] slack;
  logic [LAT_W-1:0] lat_eff;
  logic             hit_rs;
  logic             hit_rt;
  logic             stall;
  logic             issue;
  logic [RUN_W-1:0] stall_run;
  logic [RUN_W-1:0] stall_run_nxt;

  assign cnt[0] = '0;

  // Register 0 is hardwired, so only 1..NUM_REGS-1 carry a countdown.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    sb_counter #(
      .LAT_W (LAT_W)
    ) u_cnt (
      .clk   (Clk),
      .rst_n (Rst),
      .load  (issue && RegWrite_ID && (Dest_ID == REG_AW'(r))),
      .lat   (lat_eff),
      .cnt   (cnt[r])
    );
  end

  // Sources are compared against the pre-update counts.
  always_comb begin
    slack        = Early_ID ? LAT_W'(SLACK_ID) : LAT_W'(SLACK_EX);
    lat_eff      = (Lat_ID > MAX_LAT_V) ? MAX_LAT_V : Lat_ID;
    hit_rs       = UseRs_ID && (Rs_ID != '0) && (cnt[Rs_ID] > slack);
    hit_rt       = UseRt_ID && (Rt_ID != '0) && (cnt[Rt_ID] > slack);
    stall        = Valid_ID && !Flush_EX && (hit_rs || hit_rt);
    issue        = Valid_ID && !Flush_EX && !stall;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    FlushControl = 1'b0;
    if (Flush_EX) begin
      FlushControl = 1'b1;
    end else if (stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      FlushControl = 1'b1;
    end
    stall_run_nxt = '0;
    if (stall) stall_run_nxt = (stall_run == '1) ? stall_run : stall_run + RUN_W'(1);
  end

  // Stall accounting and stuck-stall watchdog.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      StallCycles <= '0;
      stall_run   <= '0;
      HazardError <= 1'b0;
    end else begin
      if (stall && (StallCycles != '1)) StallCycles <= StallCycles + CNT_W'(1);
      stall_run <= stall_run_nxt;
      if (stall_run_nxt >= RUN_LIMIT) HazardError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed stall counts.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned MAX_LAT  = 4;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned CNT_W    = 16;

  logic              Clk;
  logic              Rst;
  logic              Valid_ID;
  logic [REG_AW-1:0] Rs_ID;
  logic [REG_AW-1:0] Rt_ID;
  logic              UseRs_ID;
  logic              UseRt_ID;
  logic              Early_ID;
  logic              RegWrite_ID;
  logic [REG_AW-1:0] Dest_ID;
  logic [LAT_W-1:0]  Lat_ID;
  logic              Flush_EX;
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              FlushControl;
  logic [CNT_W-1:0]  StallCycles;
  logic              HazardError;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .MAX_LAT  (MAX_LAT),
    .LAT_W    (LAT_W),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Valid_ID     (Valid_ID),
    .Rs_ID        (Rs_ID),
    .Rt_ID        (Rt_ID),
    .UseRs_ID     (UseRs_ID),
    .UseRt_ID     (UseRt_ID),
    .Early_ID     (Early_ID),
    .RegWrite_ID  (RegWrite_ID),
    .Dest_ID      (Dest_ID),
    .Lat_ID       (Lat_ID),
    .Flush_EX     (Flush_EX),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .FlushControl (FlushControl),
    .StallCycles  (StallCycles),
    .HazardError  (HazardError)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic op(input int valid, input int rs, input int rt, input int use_rs,
                    input int use_rt, input int early, input int rw, input int dest,
                    input int lat);
    Valid_ID    = valid[0];
    Rs_ID       = REG_AW'(rs);
    Rt_ID       = REG_AW'(rt);
    UseRs_ID    = use_rs[0];
    UseRt_ID    = use_rt[0];
    Early_ID    = early[0];
    RegWrite_ID = rw[0];
    Dest_ID     = REG_AW'(dest);
    Lat_ID      = LAT_W'(lat);
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    Flush_EX = 1'b0;
    Rst      = 1'b0;
    tick();
    Rst      = 1'b1;
  endtask

  // Counts stall cycles of the instruction in ID, then clocks it through.
  task automatic wait_issue(input string tag, input int exp);
    int n = 0;
    settle();
    while (!PCWrite && n < 10) begin
      n++;
      tick();
      settle();
    end
    check(tag, n, exp);
    tick();
  endtask

  initial begin
    idle();
    Flush_EX = 1'b0;
    Rst      = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    settle();
    check("rst_pcw",  PCWrite,      1);
    check("rst_ifid", IF_ID_Write,  1);
    check("rst_fc",   FlushControl, 0);
    check("rst_sc",   StallCycles,  0);
    check("rst_err",  HazardError,  0);

    // Load $8 then an EX reader: exactly one stall.
    tick();
    op(1, 0, 0, 0, 0, 0, 1, 8, LAT_LOAD);
    settle();
    check("a_load_pcw", PCWrite, 1);
    tick();
    op(1, 8, 0, 1, 0, 0, 1, 11, LAT_ALU);
    settle();
    check("a_stall_pcw",  PCWrite,      0);
    check("a_stall_ifid", IF_ID_Write,  0);
    check("a_stall_fc",   FlushControl, 1);
    tick();
    settle();
    check("a_issue_pcw", PCWrite,      1);
    check("a_issue_fc",  FlushControl, 0);
    check("a_sc",        StallCycles,  1);
    tick();
    op(1, 0, 11, 0, 1, 0, 0, 0, 0);
    wait_issue("a_alu_ex", 0);

    // ALU then branch: 1 stall; load then branch: 2 stalls.
    do_reset();
    op(1, 0, 0, 0, 0, 0, 1, 9, LAT_ALU);
    tick();
    op(1, 9, 0, 1, 0, 1, 0, 0, 0);
    wait_issue("b_alu_br", 1);
    op(1, 0, 0, 0, 0, 0, 1, 9, LAT_LOAD);
    tick();
    op(1, 0, 9, 0, 1, 1, 0, 0, 0);
    wait_issue("b_ld_br", 2);
    idle();
    settle();
    check("b_sc", StallCycles, 3);

    // Younger shorter write must not shorten the older load count.
    do_reset();
    op(1, 0, 0, 0, 0, 0, 1, 10, 4);
    tick();
    op(1, 0, 0, 0, 0, 0, 1, 10, LAT_ALU);
    tick();
    op(1, 10, 0, 1, 0, 1, 0, 0, 0);
    wait_issue("c_max", 3);

    // Oversized latency clamps to MAX_LAT.
    op(1, 0, 0, 0, 0, 0, 1, 14, 7);
    tick();
    op(1, 14, 0, 1, 0, 1, 0, 0, 0);
    wait_issue("c_clamp", 4);

    // Writes to $0 and zero-latency writes are never tracked.
    op(1, 0, 0, 0, 0, 0, 1, 0, 4);
    tick();
    op(1, 0, 0, 1, 1, 1, 0, 0, 0);
    wait_issue("d_reg0", 0);
    op(1, 0, 0, 0, 0, 0, 1, 15, 0);
    tick();
    op(1, 15, 0, 1, 0, 1, 0, 0, 0);
    wait_issue("d_lat0", 0);

    // Flush beats a hazard and the flushed instruction leaves no count behind.
    do_reset();
    op(1, 0, 0, 0, 0, 0, 1, 12, LAT_LOAD);
    tick();
    op(1, 12, 0, 1, 0, 1, 1, 13, 4);
    Flush_EX = 1'b1;
    settle();
    check("e_pcw",  PCWrite,      1);
    check("e_ifid", IF_ID_Write,  1);
    check("e_fc",   FlushControl, 1);
    tick();
    Flush_EX = 1'b0;
    op(1, 13, 0, 1, 0, 1, 0, 0, 0);
    settle();
    check("e_nowrite", PCWrite,     1);
    check("e_sc",      StallCycles, 0);
    tick();

    // Held count drives a stuck stall into the watchdog, then reset mid-stall.
    do_reset();
    force dut.g_sb[8].u_cnt.cnt_q = 3'd4;
    op(1, 8, 0, 1, 0, 1, 0, 0, 0);
    settle();
    check("f_stall", PCWrite, 0);
    repeat (MAX_LAT) tick();
    settle();
    check("f_err_pre", HazardError, 0);
    tick();
    settle();
    check("f_err",      HazardError, 1);
    check("f_sc",       StallCycles, MAX_LAT + 1);
    check("f_still_st", PCWrite,     0);
    tick();
    settle();
    check("f_err_hold", HazardError, 1);
    release dut.g_sb[8].u_cnt.cnt_q;
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    settle();
    check("f_rst_pcw", PCWrite,      1);
    check("f_rst_fc",  FlushControl, 0);
    check("f_rst_sc",  StallCycles,  0);
    check("f_rst_err", HazardError,  0);
    tick();
    idle();
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
